divider_iter: RTL and testbench



---
 rtl/divider_iter.sv | 163 ++++++++++++++++
 tb/tb_divider_iter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_iter.sv
// Multi-cycle restoring divider with valid/ready on both sides, BPC quotient bits per clock.
// Define DIVIDER_ITER_SIGNED_EN to honour the two's-complement `sign` input; otherwise operands are unsigned.
module divider_iter #(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_dvs;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;

  // Operand conditioning: magnitudes in WIDTH+1 bits so |MIN| is representable.
  logic             w_sign_eff;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH:0]   w_ext_a, w_ext_b, w_mag_a, w_mag_b;
  logic             w_div_zero;

`ifdef DIVIDER_ITER_SIGNED_EN
  assign w_sign_eff = sign;
`else
  assign w_sign_eff = 1'b0;
`endif

  assign w_a_neg    = w_sign_eff & dividend[WIDTH-1];
  assign w_b_neg    = w_sign_eff & divisor[WIDTH-1];
  assign w_ext_a    = {w_a_neg, dividend};
  assign w_ext_b    = {w_b_neg, divisor};
  assign w_mag_a    = w_a_neg ? -w_ext_a : w_ext_a;
  assign w_mag_b    = w_b_neg ? -w_ext_b : w_ext_b;
  assign w_div_zero = (divisor == '0);

  // BPC restoring sub-steps per clock; quotient bits shift in where dividend bits shift out.
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;

  always_comb begin
    // NOTE: every comb output gets a default before any branch so no latch is inferred.
    w_rem_nxt = r_rem;
    w_quo_nxt = r_quo;
    w_shift   = '0;
    w_diff    = '0;
    for (int k = 0; k < BPC; k++) begin
      w_shift   = {w_rem_nxt, w_quo_nxt[WIDTH-1]};
      w_diff    = {1'b0, w_shift} - {1'b0, r_dvs};
      w_quo_nxt = {w_quo_nxt[WIDTH-2:0], ~w_diff[WIDTH+1]};
      w_rem_nxt = w_diff[WIDTH+1] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end
  end

  // Sign correction applied on the way into the result registers.
  logic [WIDTH-1:0] w_fix_quo, w_fix_rem;

`ifdef DIVIDER_ITER_SIGNED_EN
  logic r_neg_q, r_neg_r;
  assign w_fix_quo = r_neg_q ? -r_quo : r_quo;
  assign w_fix_rem = r_neg_r ? -r_rem : r_rem;
`else
  assign w_fix_quo = r_quo;
  assign w_fix_rem = r_rem;
`endif

  // Bits that are structurally constant or only meaningful in the signed build.
  logic [2:0] w_unused_bits;
  assign w_unused_bits = {sign, w_mag_a[WIDTH], w_diff[WIDTH]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_div_zero ? DONE : BUSY;
      BUSY:    if (r_cnt == CNT_LAST) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
`ifdef DIVIDER_ITER_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rem <= '0;
            r_quo <= w_mag_a[WIDTH-1:0];
            r_dvs <= w_mag_b;
`ifdef DIVIDER_ITER_SIGNED_EN
            r_neg_q <= w_sign_eff & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= w_a_neg;
`endif
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_div_zero  <= 1'b1;
            end else begin
              r_cnt <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CNT_LAST;
        end
        FIX: begin
          r_quotient  <= w_fix_quo;
          r_remainder <= w_fix_rem;
          r_div_zero  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_divider_iter.sv
// Bench for divider_iter: an 8-bit/BPC=1 and a 16-bit/BPC=4 instance, table vectors,
// random operands against an arithmetic model, backpressure and mid-operation reset sequences.
module tb_divider_iter;

`ifdef DIVIDER_ITER_SIGNED_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic clk, reset_n;
  logic iv8, ir8, sg8, ov8, or8, dz8;
  logic [7:0] a8, b8, q8, r8;
  logic iv16, ir16, sg16, ov16, or16, dz16;
  logic [15:0] a16, b16, q16, r16;

  int n_checks = 0;
  int n_fail   = 0;

  divider_iter #(.WIDTH(8), .BPC(1)) u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .sign(sg8),
    .dividend(a8), .divisor(b8), .out_valid(ov8), .out_ready(or8),
    .quotient(q8), .remainder(r8), .div_zero(dz8));

  divider_iter #(.WIDTH(16), .BPC(4)) u16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16), .sign(sg16),
    .dividend(a16), .divisor(b16), .out_valid(ov16), .out_ready(or16),
    .quotient(q16), .remainder(r16), .div_zero(dz16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic        s;
    logic [15:0] a, b, q, r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int sel, logic s, logic [15:0] a, logic [15:0] b,
                              logic [15:0] q, logic [15:0] r, logic dz, int lat);
    vec_t v;
    v.sel = sel; v.s = s; v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_ir(int sel); return (sel != 0) ? ir16 : ir8; endfunction
  function automatic logic get_ov(int sel); return (sel != 0) ? ov16 : ov8; endfunction
  function automatic logic get_dz(int sel); return (sel != 0) ? dz16 : dz8; endfunction
  function automatic logic [15:0] get_q(int sel); return (sel != 0) ? q16 : {8'h00, q8}; endfunction
  function automatic logic [15:0] get_r(int sel); return (sel != 0) ? r16 : {8'h00, r8}; endfunction

  task automatic drive(input int sel, input logic v, input logic s, input logic [15:0] a, input logic [15:0] b);
    if (sel == 0) begin iv8 = v; sg8 = s; a8 = a[7:0]; b8 = b[7:0]; end
    else begin iv16 = v; sg16 = s; a16 = a; b16 = b; end
  endtask

  task automatic set_or(input int sel, input logic v);
    if (sel == 0) or8 = v; else or16 = v;
  endtask

  // Reference: integer arithmetic, C-style truncating division on the decoded operand values.
  function automatic void model(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r, output logic dz);
    int mask, ua, ub, av, bv, qi, ri;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    if (ub == 0) begin
      q = 16'(mask); r = 16'(ua); dz = 1'b1;
      return;
    end
    if (SE && s) begin
      av = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      bv = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      qi = av / bv;
      ri = av % bv;
    end else begin
      qi = ua / ub;
      ri = ua % ub;
    end
    q = 16'(qi & mask); r = 16'(ri & mask); dz = 1'b0;
  endfunction

  task automatic do_op(input string tag, input int sel, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edz, input int elat);
    int lat;
    lat = -1;
    @(negedge clk);
    check({tag, "_ready_before"}, get_ir(sel), 1);
    drive(sel, 1'b1, s, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
    check({tag, "_ready_low"}, get_ir(sel), 0);
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (get_ov(sel)) begin lat = k; break; end
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, get_q(sel), eq);
    check({tag, "_r"}, get_r(sel), er);
    check({tag, "_dz"}, get_dz(sel), edz);
    @(negedge clk); set_or(sel, 1'b1);
    @(posedge clk); #1; set_or(sel, 1'b0);
    check({tag, "_idle_ready"}, get_ir(sel), 1);
    check({tag, "_idle_valid"}, get_ov(sel), 0);
    check({tag, "_idle_hold_q"}, get_q(sel), eq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] eq, er, a, b, mask;
    logic        edz, s;
    int          sel, w, pick, bound;

    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    or8 = 1'b0; or16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("rst_ready8", ir8, 1);
    check("rst_valid8", ov8, 0);
    check("rst_q8", q8, 0);
    check("rst_r8", r8, 0);
    check("rst_dz8", dz8, 0);
    check("rst_ready16", ir16, 1);
    check("rst_valid16", ov16, 0);
    check("rst_q16", q16, 0);

    vecs.push_back(mk(0, 1'b0, 16'd100,  16'd7,   16'd14,   16'd2,  1'b0, 9));
    vecs.push_back(mk(0, 1'b0, 16'd55,   16'd0,   16'h00FF, 16'd55, 1'b1, 1));
    vecs.push_back(mk(0, 1'b1, 16'd55,   16'd0,   16'h00FF, 16'd55, 1'b1, 1));
    vecs.push_back(mk(0, 1'b0, 16'd255,  16'd1,   16'd255,  16'd0,  1'b0, 9));
    vecs.push_back(mk(0, 1'b0, 16'd7,    16'd100, 16'd0,    16'd7,  1'b0, 9));
    vecs.push_back(mk(0, 1'b0, 16'd200,  16'd200, 16'd1,    16'd0,  1'b0, 9));
    vecs.push_back(mk(0, 1'b0, 16'd0,    16'd5,   16'd0,    16'd0,  1'b0, 9));
    vecs.push_back(mk(1, 1'b0, 16'hFFFF, 16'd3,   16'h5555, 16'd0,  1'b0, 5));
    vecs.push_back(mk(1, 1'b0, 16'h1234, 16'd0,   16'hFFFF, 16'h1234, 1'b1, 1));
`ifdef DIVIDER_ITER_SIGNED_EN
    vecs.push_back(mk(0, 1'b1, 16'h009C, 16'd7,    16'h00F2, 16'h00FE, 1'b0, 9));
    vecs.push_back(mk(0, 1'b1, 16'd100,  16'h00F9, 16'h00F2, 16'd2,    1'b0, 9));
    vecs.push_back(mk(0, 1'b1, 16'h009C, 16'h00F9, 16'd14,   16'h00FE, 1'b0, 9));
    vecs.push_back(mk(0, 1'b1, 16'h0080, 16'h00FF, 16'h0080, 16'd0,    1'b0, 9));
    vecs.push_back(mk(1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 5));
`else
    vecs.push_back(mk(0, 1'b1, 16'h009C, 16'd7,    16'd22,   16'd2,    1'b0, 9));
    vecs.push_back(mk(0, 1'b1, 16'd100,  16'h00F9, 16'd0,    16'd100,  1'b0, 9));
    vecs.push_back(mk(0, 1'b1, 16'h009C, 16'h00F9, 16'd0,    16'h009C, 1'b0, 9));
    vecs.push_back(mk(0, 1'b1, 16'h0080, 16'h00FF, 16'd0,    16'h0080, 1'b0, 9));
    vecs.push_back(mk(1, 1'b1, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 5));
`endif
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].s, vecs[i].a, vecs[i].b,
            vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);

    for (int i = 0; i < 60; i++) begin
      sel  = i % 2;
      w    = (sel != 0) ? 16 : 8;
      mask = 16'((1 << w) - 1);
      s    = 1'($urandom_range(0, 1));
      a    = 16'($urandom) & mask;
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      b = 16'h0;
      else if (pick == 1) b = mask;
      else if (pick == 2) begin a = 16'(1 << (w - 1)); b = mask; end
      else                b = 16'($urandom) & mask;
      model(w, s, a, b, eq, er, edz);
      do_op($sformatf("rnd%0d", i), sel, s, a, b, eq, er, edz, edz ? 1 : ((sel != 0) ? 5 : 9));
    end

    // Backpressure: result must hold and a stray in_valid must be ignored.
    @(negedge clk); drive(0, 1'b1, 1'b0, 16'd100, 16'd7);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    bound = 0;
    while (!ov8 && bound < 64) begin @(posedge clk); #1; bound++; end
    check("bp_valid_rise", ov8, 1);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin @(negedge clk); drive(0, 1'b1, 1'b0, 16'd9, 16'd4); end
      @(posedge clk); #1;
      if (c == 2) drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      check($sformatf("bp%0d_valid", c), ov8, 1);
      check($sformatf("bp%0d_q", c), q8, 14);
      check($sformatf("bp%0d_r", c), r8, 2);
      check($sformatf("bp%0d_ready", c), ir8, 0);
    end
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;
    check("bp_ready_after", ir8, 1);
    check("bp_valid_after", ov8, 0);
    do_op("bp_next", 0, 1'b0, 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 9);

    // Reset three cycles into BUSY abandons the operation at once.
    @(negedge clk); drive(0, 1'b1, 1'b0, 16'd100, 16'd7);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mrst_valid", ov8, 0);
    check("mrst_ready", ir8, 1);
    check("mrst_q", q8, 0);
    check("mrst_r", r8, 0);
    check("mrst_dz", dz8, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    do_op("mrst_next", 0, 1'b0, 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
